divrem_seq: RTL and testbench
=============================

Name: divrem_seq

Overview:
- Multi-cycle sequencer for the integer DIV/DIVU/REM/REMU unit in the EX stage.
- Takes a start request from EX and captures the operands.
- Runs an iterative shift-subtract datapath, one quotient bit per cycle.
- Drives the pipeline-wide stall request consumed by the forwarding/hazard unit, so a handshake replaces the fixed-count DIVREM stall.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- iCLK  in  1  core clock
- iRST  in  1  reset, asynchronous, active-high
- iStart  in  1  EX holds a DivRem instruction (EX InstrType[7])
- iFunct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- iA  in  WIDTH  dividend (forwarded rs1)
- iB  in  WIDTH  divisor (forwarded rs2)
- iFlush  in  1  MEM exception flush; aborts the operation in progress
- oStall  out  1  freeze IF/ID/EX/MEM/WB
- oBusy  out  1  state is CALC
- oReady  out  1  result valid this cycle
- oResult  out  WIDTH  quotient or remainder selected by iFunct3

Behaviour:
- Reset (asynchronous):
  - state goes to IDLE; counter 0; internal registers 0.
  - oBusy=0, oReady=0, oResult=0.
  - oStall=0 unless iStart is already asserted (combinational term below).
- States: IDLE, CALC, DONE, with 2-bit encoding from the package.
- IDLE:
  - oStall = iStart & ~iFlush, combinational, so there is no bubble.
  - On iStart & ~iFlush, capture the inputs:
    - sign flags: signed ops only, taken from bit WIDTH-1 of iA and iB.
    - |iA| and |iB|; iFunct3.
  - Fast path on the same edge, going straight to DONE:
    - Divisor zero: quotient = all ones; remainder = iA.
    - Signed overflow (iA = 0x80000000, iB = all ones, DIV/REM only): quotient = 0x80000000; remainder = 0.
  - Otherwise go to CALC with counter = 0.
- CALC:
  - oStall=1, oBusy=1.
  - Each cycle performs one restoring step in the core; counter += 1.
  - When counter = WIDTH-1 the step completes, the sign fix-up is applied, and the state goes to DONE.
  - Normal-path stall is therefore WIDTH+1 cycles: 1 in IDLE plus WIDTH in CALC.
- Sign fix-up:
  - Quotient is negated iff signed op and signA xor signB.
  - Remainder is negated iff signed op and signA.
  - DONE cycle only: oResult = quotient for funct3[1]=0, remainder for funct3[1]=1.
- DONE:
  - oStall=0, oReady=1; oResult is stable for the whole cycle.
  - The pipeline advances on this edge and the state unconditionally returns to IDLE.
  - iStart is ignored in DONE, so the same instruction cannot restart.
  - A following DivRem sees IDLE on the next cycle.
- Outside DONE: oReady=0, and oResult holds its last value.
- Operand isolation: iA, iB and iFunct3 are ignored after capture.
- Flush handling:
  - iFlush in CALC: go to IDLE next edge; oStall drops that cycle (combinational ~iFlush term); no oReady.
  - iFlush in DONE: go to IDLE; oReady still asserted for that cycle; the downstream flush discards the result.
  - iFlush together with iStart in IDLE: no capture, and oStall=0.
- Reset asserted mid-CALC aborts immediately; no partial result is visible.
- Arithmetic:
  - Unsigned magnitudes throughout.
  - The partial remainder is WIDTH+1 bits, so the trial subtraction keeps its borrow.
  - Negation is two's complement, truncated to WIDTH.

Decomposition:
- Package divrem_pkg holds:
  - funct3 codes FN_DIV/FN_DIVU/FN_REM/FN_REMU
  - state encoding S_IDLE/S_CALC/S_DONE
  - default WIDTH
- Sub-module divrem_core:
  - Registered quotient/remainder shift datapath.
  - Inputs: load, step, dividend and divisor magnitudes.
  - Outputs: quotient and remainder magnitudes.
  - No FSM.
- divrem_seq owns the FSM, counter, fast-path detection, sign fix-up, output mux and stall logic.

Test Plan:
- DIV iA=-7 (0xFFFFFFF9), iB=2 -> oStall high for 33 cycles, then oReady=1 for 1 cycle with oResult=0xFFFFFFFD. Repeating with REM -> oResult=0xFFFFFFFF.
- DIVU iA=100, iB=7 -> 14 in the DONE cycle. REMU with the same operands -> 2. iA/iB toggled during CALC must not change the result.
- Divide-by-zero: DIV 5/0 -> one stall cycle, then DONE with 0xFFFFFFFF. REM 5/0 -> 5. DIVU 0/0 -> 0xFFFFFFFF.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after a 1-cycle stall. REM with the same operands -> 0.
- Back-to-back DIVU 9/3 then REMU 9/4:
  - first op gives 3 in its DONE cycle, then exactly one IDLE cycle follows;
  - second op stalls 33 cycles and gives 1;
  - no double start of the first op.
- iFlush asserted at CALC cycle 10 -> IDLE next edge, oStall=0 in the flush cycle, oReady never asserted. iRST pulse mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/divrem_pkg.sv
// Shared constants for the iterative DIV/DIVU/REM/REMU unit: funct3 codes,
// sequencer state encoding and the default datapath width.
package divrem_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [2:0] FN_DIV  = 3'b100;
  localparam logic [2:0] FN_DIVU = 3'b101;
  localparam logic [2:0] FN_REM  = 3'b110;
  localparam logic [2:0] FN_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/divrem_seq_if.sv
// EX-stage request/response bundle between the pipeline and the divide sequencer.
interface divrem_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iStart;
  logic [2:0]       iFunct3;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iFlush;
  logic             oStall;
  logic             oBusy;
  logic             oReady;
  logic [WIDTH-1:0] oResult;

  modport master (
    output iStart, iFunct3, iA, iB, iFlush,
    input  oStall, oBusy, oReady, oResult
  );

  modport slave (
    input  iStart, iFunct3, iA, iB, iFlush,
    output oStall, oBusy, oReady, oResult
  );
endinterface

// File: rtl/divrem_core.sv
// Restoring shift-subtract datapath on unsigned magnitudes: one quotient bit per step.
// The dividend shifts out of the quotient register as quotient bits shift in.
module divrem_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    div_d  = div_q;
    // Extra top bit keeps the borrow of the trial subtraction.
    trial  = {rem_q, quot_q[WIDTH-1]};
    diff   = trial - {1'b0, div_q};
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      div_d  = divisor_i;
    end else if (step_i) begin
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/divrem_seq.sv
// Divide/remainder sequencer: FSM, iteration counter, fast paths, sign fix-up and the
// pipeline stall handshake around divrem_core.
module divrem_seq
  import divrem_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic         iCLK,
  input logic         iRST,
  divrem_seq_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             signed_q, signed_d;
  logic             sel_rem_q, sel_rem_d;
  logic             fast_q, fast_d;
  logic [WIDTH-1:0] fast_res_q, fast_res_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             core_load, core_step;
  logic [WIDTH-1:0] quot_mag, rem_mag, quot_fix, rem_fix;
  logic             in_signed, in_sign_a, in_sign_b, in_go;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             stall, busy, ready;
  logic [WIDTH-1:0] result;
  logic             unused_funct3;

  assign unused_funct3 = bus.iFunct3[2];

  assign in_go     = bus.iStart & ~bus.iFlush;
  assign in_signed = ~bus.iFunct3[0];
  assign in_sign_a = in_signed & bus.iA[WIDTH-1];
  assign in_sign_b = in_signed & bus.iB[WIDTH-1];
  assign abs_a     = in_sign_a ? -bus.iA : bus.iA;
  assign abs_b     = in_sign_b ? -bus.iB : bus.iB;

  assign quot_fix = (signed_q & (sign_a_q ^ sign_b_q)) ? -quot_mag : quot_mag;
  assign rem_fix  = (signed_q & sign_a_q) ? -rem_mag : rem_mag;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    signed_d   = signed_q;
    sel_rem_d  = sel_rem_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    res_d      = res_q;
    core_load  = 1'b0;
    core_step  = 1'b0;
    stall      = 1'b0;
    busy       = 1'b0;
    ready      = 1'b0;
    result     = res_q;

    unique case (state_q)
      S_IDLE: begin
        stall = in_go;
        if (in_go) begin
          core_load = 1'b1;
          cnt_d     = '0;
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          signed_d  = in_signed;
          sel_rem_d = bus.iFunct3[1];
          fast_d    = 1'b1;
          if (bus.iB == '0) begin
            fast_res_d = bus.iFunct3[1] ? bus.iA : '1;
            state_d    = S_DONE;
          end else if (in_signed && bus.iA == MinNeg && (&bus.iB)) begin
            fast_res_d = bus.iFunct3[1] ? '0 : MinNeg;
            state_d    = S_DONE;
          end else begin
            fast_d  = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Stall drops combinationally so a flushed pipeline is not held an extra cycle.
        stall = ~bus.iFlush;
        busy  = 1'b1;
        if (bus.iFlush) begin
          state_d = S_IDLE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        result  = fast_q ? fast_res_q : (sel_rem_q ? rem_fix : quot_fix);
        res_d   = result;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      signed_q   <= 1'b0;
      sel_rem_q  <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      signed_q   <= signed_d;
      sel_rem_q  <= sel_rem_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
      res_q      <= res_d;
    end
  end

  divrem_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .load_i     (core_load),
    .step_i     (core_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quot_o     (quot_mag),
    .rem_o      (rem_mag)
  );

  assign bus.oStall  = stall;
  assign bus.oBusy   = busy;
  assign bus.oReady  = ready;
  assign bus.oResult = result;

endmodule

// File: tb/tb_divrem_seq.sv
// Bench for divrem_seq: vector table driven through a result scoreboard, plus
// hand sequences for back-to-back, flush and mid-operation reset.
module tb_divrem_seq;
  import divrem_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ready_cnt = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  divrem_seq_if #(.WIDTH(32)) bus ();

  divrem_seq #(.WIDTH(32)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every oReady pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.oReady === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got %h expected no result at %0t", bus.oResult, $time);
      end else begin
        check("result", bus.oResult, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall, input bit b2b);
    int stalls = 0;
    int busies = 0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    bus.iStart  = 1'b1;
    bus.iFunct3 = f3;
    bus.iA      = a;
    bus.iB      = b;
    exp_q.push_back(exp);
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bus.oReady === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.oStall === 1'b1) stalls++;
        if (bus.oBusy === 1'b1) begin
          busies++;
          // Operands are captured; scramble them to prove isolation.
          bus.iA      = $urandom;
          bus.iB      = $urandom;
          bus.iFunct3 = {1'b1, 2'($urandom_range(3))};
        end
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    check("stall_cycles", stalls, exp_stall);
    check("busy_cycles", busies, exp_stall - 1);
    if (!b2b) begin
      @(posedge clk);
      #1;
      bus.iStart = 1'b0;
      @(negedge clk);
      check("post_ready", 32'(bus.oReady), 32'd0);
      check("post_stall", 32'(bus.oStall), 32'd0);
      check("result_hold", bus.oResult, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int busies;
    int rc;
    bus.iStart  = 1'b0;
    bus.iFunct3 = FN_DIV;
    bus.iA      = '0;
    bus.iB      = '0;
    bus.iFlush  = 1'b0;

    vecs.push_back('{FN_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{FN_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{FN_DIVU, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{FN_REMU, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{FN_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{FN_REM,  32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{FN_DIVU, 32'd0,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{FN_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
    vecs.push_back('{FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{FN_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{FN_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{FN_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33});
    vecs.push_back('{FN_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33});
    vecs.push_back('{FN_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33});
    vecs.push_back('{FN_DIVU, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33});
    vecs.push_back('{FN_REMU, 32'hFFFF_FFFF, 32'd10,        32'd5,         33});
    vecs.push_back('{FN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{FN_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
    vecs.push_back('{FN_REMU, 32'd3,         32'd5,         32'd3,         33});

    // Reset state, including the combinational stall term under reset.
    #12;
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_ready", 32'(bus.oReady), 32'd0);
    check("rst_result", bus.oResult, 32'd0);
    check("rst_stall", 32'(bus.oStall), 32'd0);
    bus.iStart = 1'b1;
    #1;
    check("rst_stall_start", 32'(bus.oStall), 32'd1);
    bus.iStart = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, 1'b0);
    end

    // Back-to-back: second op starts in the IDLE cycle right after DONE.
    rc = ready_cnt;
    run_op(FN_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);
    run_op(FN_REMU, 32'd9, 32'd4, 32'd1, 33, 1'b0);
    check("b2b_ready_count", ready_cnt - rc, 32'd2);

    // Flush together with start in IDLE: nothing captured.
    @(posedge clk);
    #1;
    bus.iStart  = 1'b1;
    bus.iFunct3 = FN_DIVU;
    bus.iA      = 32'd50;
    bus.iB      = 32'd3;
    bus.iFlush  = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 32'(bus.oStall), 32'd0);
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    bus.iFlush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 32'(bus.oBusy), 32'd0);

    // Flush at CALC cycle 10.
    rc = ready_cnt;
    @(posedge clk);
    #1;
    bus.iStart  = 1'b1;
    bus.iFunct3 = FN_DIVU;
    bus.iA      = 32'd1000;
    bus.iB      = 32'd3;
    busies = 0;
    for (int c = 0; c < 50 && busies < 10; c++) begin
      @(negedge clk);
      if (bus.oBusy === 1'b1) busies++;
    end
    bus.iFlush = 1'b1;
    #1;
    check("calc_flush_stall", 32'(bus.oStall), 32'd0);
    check("calc_flush_busy", 32'(bus.oBusy), 32'd1);
    @(posedge clk);
    #1;
    bus.iFlush = 1'b0;
    bus.iStart = 1'b0;
    @(negedge clk);
    check("after_flush_busy", 32'(bus.oBusy), 32'd0);
    check("after_flush_stall", 32'(bus.oStall), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_ready", ready_cnt - rc, 32'd0);

    // Flush in DONE: the result is still presented for that cycle.
    @(posedge clk);
    #1;
    bus.iStart  = 1'b1;
    bus.iFunct3 = FN_DIVU;
    bus.iA      = 32'd100;
    bus.iB      = 32'd7;
    exp_q.push_back(32'd14);
    for (int c = 0; c < 60 && bus.oReady !== 1'b1; c++) @(negedge clk);
    bus.iFlush = 1'b1;
    #1;
    check("done_flush_ready", 32'(bus.oReady), 32'd1);
    @(posedge clk);
    #1;
    bus.iFlush = 1'b0;
    bus.iStart = 1'b0;
    @(negedge clk);
    check("done_flush_idle", 32'(bus.oBusy | bus.oReady | bus.oStall), 32'd0);

    // Asynchronous reset mid-CALC.
    @(posedge clk);
    #1;
    bus.iStart  = 1'b1;
    bus.iFunct3 = FN_DIVU;
    bus.iA      = 32'd1000;
    bus.iB      = 32'd3;
    busies = 0;
    for (int c = 0; c < 50 && busies < 5; c++) begin
      @(negedge clk);
      if (bus.oBusy === 1'b1) busies++;
    end
    #2;
    rst        = 1'b1;
    bus.iStart = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.oBusy), 32'd0);
    check("mid_rst_stall", 32'(bus.oStall), 32'd0);
    check("mid_rst_ready", 32'(bus.oReady), 32'd0);
    check("mid_rst_result", bus.oResult, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(FN_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
